drawing_control_fsm: RTL
========================

Name: drawing_control_fsm

Overview:
Sequencing controller for the cell-drawing datapath. It produces the 3-bit state code that the datapath decodes: IDLE 0, MOVE 1, WAIT 2, CLEAN 3, DRAW 4, ERASE 5, CLEAR_WAIT 6, CLEAR 7. It consumes the datapath's done and move flags and the user draw/erase/clear requests. It adds input synchronisation, request priority, a power-up screen clear, a WAIT delay and a done-timeout watchdog.

Parameters:
WAIT_CYCLES, 2, cycles spent in WAIT before CLEAN; minimum 1; values below 1 are treated as 1.
DONE_TIMEOUT, 400000, maximum cycles in a busy state without done before abort; must exceed 640*480 plus margin.
IDLE_DWELL, 2, minimum cycles in IDLE before dispatch, so datapath done/move flags have refreshed.
SYNC_STAGES, 2, flip-flop stages on each asynchronous request input.

Ports:
iClk  in  1  system clock
iReset  in  1  synchronous, active-high reset
iDone  in  1  datapath done flag (registered, level)
iMove  in  1  datapath cell-change flag (registered, level)
iDrawReq  in  1  async level: user wants to paint the current cell
iEraseReq  in  1  async level: user wants to erase the current cell
iClearReq  in  1  async level: clear-screen button
oState  out  3  state code to the datapath
oBusy  out  1  high whenever oState != IDLE
oClearDone  out  1  one-cycle pulse when a CLEAR completes
oTimeout  out  1  sticky watchdog error flag

Behaviour:
- Single clock. Reset is synchronous and active-high.
- Reset values:
  - oState=IDLE, oBusy=0, oClearDone=0, oTimeout=0.
  - All counters are 0.
  - Synchroniser flops are 0.
  - pending_clear=1, which forces a power-up clear.
- All outputs are registered. oState changes only on a clock edge.
- Synchronisers: each request input passes through SYNC_STAGES flops. A clear_rise is detected from the synchronised iClearReq (previous sample 0, current sample 1).
- pending_clear is set by clear_rise in any state, and cleared when the FSM enters CLEAR_WAIT.
- IDLE:
  - The dwell counter counts up from 0. No dispatch happens until it reaches IDLE_DWELL-1.
  - Dispatch priority, evaluated in the cycle when dwell completes and every IDLE cycle after:
    1. pending_clear -> CLEAR_WAIT.
    2. iMove -> MOVE.
    3. synced draw -> DRAW.
    4. synced erase -> ERASE.
    5. Otherwise stay in IDLE.
  - Draw and erase asserted together: draw wins.
  - Requests are level-sensitive. A held draw re-dispatches DRAW after every return to IDLE.
- MOVE: stay until iDone=1, then go to WAIT.
- WAIT: count WAIT_CYCLES cycles, then go to CLEAN. The datapath drops iDone during WAIT.
- CLEAN: stay until iDone=1, then go to IDLE.
- DRAW and ERASE: stay until iDone=1, then go to IDLE.
- CLEAR_WAIT: stay while synced iClearReq=1, i.e. until the button is released. Go to CLEAR on the first cycle it reads 0. The power-up case therefore passes straight through.
- CLEAR: stay until iDone=1, then go to IDLE and pulse oClearDone high for exactly one cycle, coincident with oState returning to IDLE.
- Watchdog (busy states MOVE, CLEAN, DRAW, ERASE, CLEAR):
  - The counter resets on every state entry and increments each cycle.
  - If it reaches DONE_TIMEOUT-1 with iDone=0: go to IDLE and set oTimeout=1.
  - oTimeout stays set until iReset.
  - A timeout in CLEAR does not pulse oClearDone.
- iDone is ignored in IDLE, WAIT and CLEAR_WAIT. A stale high iDone there never causes a transition.
- Every state transition resets the dwell, wait and watchdog counters.
- Counter widths: $clog2 of the respective parameter plus 1. No wrap is possible because every counter is bounded by its compare.
- Reset mid-operation (e.g. during CLEAR): the next edge returns oState to IDLE with pending_clear=1, so the screen is cleared again.
- Codes are decoded with a full case statement. Any unreachable code returns to IDLE.

Decomposition:
- Shared package drawing_pkg holds:
  - State code localparams: ST_IDLE=3'd0 through ST_CLEAR=3'd7.
  - Default screen dimensions.
  - DONE_TIMEOUT default.
- The datapath and this FSM both import the state codes from drawing_pkg.
- One natural sub-module: sync_edge, an SYNC_STAGES-deep synchroniser with rising-edge output, instantiated three times (draw, erase, clear; the edge output is used only for clear).

Test Plan:
1. Power-up clear:
   - Stimulus: iReset high 3 cycles then low; all requests 0; model raises iDone 307200 cycles after CLEAR entry.
   - Required: oState sequence 0,6,7,0; oClearDone high for one cycle; oTimeout=0.
2. Move path:
   - Stimulus: in IDLE, raise iMove; iDone high 25 cycles after MOVE entry.
   - Required: 0 -> 1 -> 2; WAIT lasts exactly 2 cycles; then 3 -> 0 on the second iDone.
3. Priority:
   - Stimulus: iMove=1, draw=1, erase=1 together in IDLE.
   - Required: MOVE is taken first. After return to IDLE with iMove=0, DRAW (4) is entered, never ERASE (5).
4. Clear hold:
   - Stimulus: pulse iClearReq high for 50 cycles during a DRAW.
   - Required: DRAW completes; then state 6 holds until 2 cycles after the button releases; then state 7.
5. Watchdog:
   - Stimulus: DONE_TIMEOUT=100; enter ERASE and never assert iDone.
   - Required: after 100 cycles oState=0 and oTimeout=1; oTimeout persists until iReset.
6. Stale done:
   - Stimulus: hold iDone=1 continuously in IDLE and WAIT.
   - Required: no transition out of WAIT before 2 cycles; IDLE never dispatches before 2 dwell cycles.

Source files
------------

// File: rtl/drawing_pkg.sv
// Shared definitions for the cell-drawing datapath and its control FSM.
// Contents:
//   - ST_* state codes decoded by the datapath.
//   - state_e, the FSM state type built on those codes.
//   - Default screen dimensions and the default done-timeout.
package drawing_pkg;

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_MOVE       = 3'd1;
  localparam logic [2:0] ST_WAIT       = 3'd2;
  localparam logic [2:0] ST_CLEAN      = 3'd3;
  localparam logic [2:0] ST_DRAW       = 3'd4;
  localparam logic [2:0] ST_ERASE      = 3'd5;
  localparam logic [2:0] ST_CLEAR_WAIT = 3'd6;
  localparam logic [2:0] ST_CLEAR      = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE       = ST_IDLE,
    S_MOVE       = ST_MOVE,
    S_WAIT       = ST_WAIT,
    S_CLEAN      = ST_CLEAN,
    S_DRAW       = ST_DRAW,
    S_ERASE      = ST_ERASE,
    S_CLEAR_WAIT = ST_CLEAR_WAIT,
    S_CLEAR      = ST_CLEAR
  } state_e;

  localparam int SCREEN_W         = 640;
  localparam int SCREEN_H         = 480;
  // A full-screen clear touches every pixel once, so the watchdog needs headroom above W*H.
  localparam int DONE_TIMEOUT_DEF = 400000;

endpackage

// File: rtl/drawing_control_fsm_sync_edge.sv
// sync_edge: multi-flop synchroniser for one asynchronous level input, with a
// registered-history rising-edge detector on the synchronised level.
// Ports:
//   iClk, iReset : clock, synchronous active-high reset (all flops clear to 0)
//   iAsync       : asynchronous level input
//   oLevel       : synchronised level (last synchroniser stage)
//   oRise        : high for one cycle when oLevel goes 0 -> 1
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic iClk,
  input  logic iReset,
  input  logic iAsync,
  output logic oLevel,
  output logic oRise
);

  localparam int N = (STAGES < 1) ? 1 : STAGES;

  logic [N-1:0] sync_p;
  logic         prev_p;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      sync_p <= '0;
      prev_p <= 1'b0;
    end else begin
      sync_p[0] <= iAsync;
      for (int i = 1; i < N; i++) begin
        sync_p[i] <= sync_p[i-1];
      end
      prev_p <= sync_p[N-1];
    end
  end

  assign oLevel = sync_p[N-1];
  assign oRise  = sync_p[N-1] & ~prev_p;

endmodule

// File: rtl/drawing_control_fsm.sv
// drawing_control_fsm: sequencing controller for the cell-drawing datapath.
// Ports:
//   iClk, iReset : clock, synchronous active-high reset
//   iDone        : datapath done flag (registered level)
//   iMove        : datapath cell-change flag (registered level)
//   iDrawReq     : async level, paint current cell
//   iEraseReq    : async level, erase current cell
//   iClearReq    : async level, clear-screen button
//   oState       : 3-bit state code to the datapath
//   oBusy        : high whenever oState != IDLE
//   oClearDone   : one-cycle pulse when a CLEAR completes normally
//   oTimeout     : sticky watchdog error, cleared only by reset
module drawing_control_fsm
  import drawing_pkg::*;
#(
  parameter int WAIT_CYCLES  = 2,
  parameter int DONE_TIMEOUT = DONE_TIMEOUT_DEF,
  parameter int IDLE_DWELL   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       iClk,
  input  logic       iReset,
  input  logic       iDone,
  input  logic       iMove,
  input  logic       iDrawReq,
  input  logic       iEraseReq,
  input  logic       iClearReq,
  output logic [2:0] oState,
  output logic       oBusy,
  output logic       oClearDone,
  output logic       oTimeout
);

  localparam int WAIT_EFF  = (WAIT_CYCLES  < 1) ? 1 : WAIT_CYCLES;
  localparam int DWELL_EFF = (IDLE_DWELL   < 1) ? 1 : IDLE_DWELL;
  localparam int WD_EFF    = (DONE_TIMEOUT < 1) ? 1 : DONE_TIMEOUT;

  localparam int WAIT_W  = $clog2(WAIT_EFF)  + 1;
  localparam int DWELL_W = $clog2(DWELL_EFF) + 1;
  localparam int WD_W    = $clog2(WD_EFF)    + 1;

  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(WAIT_EFF - 1);
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_EFF - 1);
  localparam logic [WD_W-1:0]    WD_LAST    = WD_W'(WD_EFF - 1);

  logic draw_sync, erase_sync, clear_sync;
  logic clear_rise;
  logic draw_rise_unused, erase_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_draw (
    .iClk   (iClk),
    .iReset (iReset),
    .iAsync (iDrawReq),
    .oLevel (draw_sync),
    .oRise  (draw_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_erase (
    .iClk   (iClk),
    .iReset (iReset),
    .iAsync (iEraseReq),
    .oLevel (erase_sync),
    .oRise  (erase_rise_unused)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clear (
    .iClk   (iClk),
    .iReset (iReset),
    .iAsync (iClearReq),
    .oLevel (clear_sync),
    .oRise  (clear_rise)
  );

  state_e             state, state_nx;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [WD_W-1:0]    wd_cnt;
  logic               pending_clear;
  logic               dwell_done;
  logic               wd_expire;
  logic               timeout_hit;
  logic               clear_fin;
  logic               busy_state;

  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign busy_state = (state == S_MOVE) || (state == S_CLEAN) || (state == S_DRAW) ||
                      (state == S_ERASE) || (state == S_CLEAR);
  // iDone has priority over the watchdog: a done arriving on the last allowed cycle still counts.
  assign wd_expire  = busy_state && !iDone && (wd_cnt == WD_LAST);

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    clear_fin   = 1'b0;
    case (state)
      S_IDLE: begin
        if (dwell_done) begin
          if (pending_clear)   state_nx = S_CLEAR_WAIT;
          else if (iMove)      state_nx = S_MOVE;
          else if (draw_sync)  state_nx = S_DRAW;
          else if (erase_sync) state_nx = S_ERASE;
        end
      end
      S_MOVE: begin
        if (iDone)          state_nx = S_WAIT;
        else if (wd_expire) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nx = S_CLEAN;
      end
      S_CLEAN, S_DRAW, S_ERASE: begin
        if (iDone)          state_nx = S_IDLE;
        else if (wd_expire) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_CLEAR_WAIT: begin
        // Waits for button release; on power-up the button is already low.
        if (!clear_sync) state_nx = S_CLEAR;
      end
      S_CLEAR: begin
        if (iDone) begin
          state_nx  = S_IDLE;
          clear_fin = 1'b1;
        end else if (wd_expire) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iReset) begin
      state         <= S_IDLE;
      oBusy         <= 1'b0;
      oClearDone    <= 1'b0;
      oTimeout      <= 1'b0;
      dwell_cnt     <= '0;
      wait_cnt      <= '0;
      wd_cnt        <= '0;
      pending_clear <= 1'b1;
    end else begin
      state      <= state_nx;
      oBusy      <= (state_nx != S_IDLE);
      oClearDone <= clear_fin;
      if (timeout_hit) oTimeout <= 1'b1;

      if (state_nx != state) begin
        dwell_cnt <= '0;
        wait_cnt  <= '0;
        wd_cnt    <= '0;
      end else begin
        if (state == S_IDLE && !dwell_done) dwell_cnt <= dwell_cnt + 1'b1;
        if (state == S_WAIT)                wait_cnt  <= wait_cnt + 1'b1;
        if (busy_state)                     wd_cnt    <= wd_cnt + 1'b1;
      end

      // A fresh press always wins so it is never lost behind the clear being started.
      if (state_nx == S_CLEAR_WAIT && state != S_CLEAR_WAIT) pending_clear <= 1'b0;
      if (clear_rise)                                        pending_clear <= 1'b1;
    end
  end

  assign oState = state;

endmodule
